// File: rtl/fifo_var_delay_ram_pkg.sv
// Shared helpers for the variable-length delay line: delay clamping and
// modulo pointer arithmetic for buffer depths that need not be a power of two.
package fifo_var_delay_ram_pkg;

    function automatic int unsigned clamp_len(input logic [31:0] len, input int unsigned maxlen);
        if (len == 32'd0) begin
            return 1;
        end else if (len > maxlen) begin
            return maxlen;
        end else begin
            return len;
        end
    endfunction

    // (ptr - d) mod m, with ptr < m and 1 <= d <= m
    function automatic int unsigned wrap_sub(input int unsigned ptr, input int unsigned d,
                                             input int unsigned m);
        return (ptr >= d) ? (ptr - d) : (ptr + m - d);
    endfunction

endpackage

// File: rtl/fifo_var_delay_ram_sdp_ram_rf.sv
// Simple dual-port, read-first RAM with a registered read port; maps onto block RAM.
module sdp_ram_rf #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 30,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             re,
    input  logic [AW-1:0]    ra,
    output logic [WIDTH-1:0] rd
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_q;

    // Both accesses in one block: a same-address read sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
        if (re) begin
            rd_q <= mem[ra];
        end
    end

    assign rd = rd_q;

endmodule

// File: rtl/fifo_var_delay_ram.sv
// Programmable-length sample delay line: one RAM write and one read per sample
// tick, output registered and zero-masked until enough history has been stored.
import fifo_var_delay_ram_pkg::*;

module fifo_var_delay_ram #(
    parameter int WIDTH  = 12,
    parameter int MAXLEN = 30,
    localparam int AW = $clog2(MAXLEN)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic             sample_clk,
    input  logic [WIDTH-1:0] in,
    input  logic [31:0]      len,
    output logic [WIDTH-1:0] out
);

    localparam int FW = $clog2(MAXLEN + 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(MAXLEN - 1);
    localparam logic [FW-1:0] FULL     = FW'(MAXLEN);

    logic             sc_q, sc_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic             mask_q, mask_d;
    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] out_q, out_d;

    logic             tick;
    logic [FW-1:0]    dlen;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;

    always_comb begin
        tick       = sample_clk & ~sc_q & enable;
        sc_d       = sample_clk;
        dlen       = FW'(clamp_len(len, MAXLEN));
        rd_addr    = AW'(wrap_sub(32'(wr_ptr_q), 32'(dlen), MAXLEN));
        wr_ptr_d   = wr_ptr_q;
        fill_d     = fill_q;
        mask_d     = mask_q;
        rd_valid_d = tick;
        out_d      = out_q;
        if (tick) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            fill_d   = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
            // Slots not yet written since reset must read as silence.
            mask_d   = (dlen > fill_q);
        end
        if (rd_valid_q) begin
            out_d = mask_q ? '0 : rd_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sc_q       <= 1'b1;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            mask_q     <= 1'b1;
            rd_valid_q <= 1'b0;
            out_q      <= '0;
        end else begin
            sc_q       <= sc_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            mask_q     <= mask_d;
            rd_valid_q <= rd_valid_d;
            out_q      <= out_d;
        end
    end

    sdp_ram_rf #(
        .WIDTH (WIDTH),
        .DEPTH (MAXLEN)
    ) u_ram (
        .clk (clk),
        .we  (tick),
        .wa  (wr_ptr_q),
        .wd  (in),
        .re  (tick),
        .ra  (rd_addr),
        .rd  (rd_data)
    );

    assign out = out_q;

endmodule

// File: tb/tb_fifo_var_delay_ram.sv
// Directed plus randomized bench for fifo_var_delay_ram against a history-queue model.
module tb_fifo_var_delay_ram;

    localparam int W = 12;
    localparam int M = 30;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         enable = 1'b1;
    logic         sample_clk = 1'b0;
    logic [W-1:0] in = '0;
    logic [31:0]  len = 32'd0;
    logic [W-1:0] out;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] hist[$];   // every sample accepted since the last reset
    logic [W-1:0] exp_out = '0;

    fifo_var_delay_ram #(.WIDTH(W), .MAXLEN(M)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .sample_clk (sample_clk),
        .in         (in),
        .len        (len),
        .out        (out)
    );

    always #2 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: delay d taken from the whole history since reset; silent until
    // d samples exist.
    task automatic model_tick(input logic [W-1:0] din, input int unsigned l);
        int unsigned d;
        int unsigned k;
        d = (l == 0) ? 1 : ((l > M) ? M : l);
        k = hist.size();
        exp_out = (d <= k) ? hist[k - d] : '0;
        hist.push_back(din);
    endtask

    task automatic do_tick(input string tag, input logic [W-1:0] din, input int unsigned l,
                           input logic en);
        @(negedge clk);
        in = din; len = l; enable = en; sample_clk = 1'b1;
        @(negedge clk);
        check({tag, "_hold"}, out, exp_out);
        if (en) model_tick(din, l);
        @(negedge clk);
        sample_clk = 1'b0;
        @(negedge clk);
        check(tag, out, exp_out);
        $display("tick %-8s en=%0d len=%0d in=%0d out=%0d exp=%0d", tag, en, l, din, out, exp_out);
    endtask

    task automatic do_reset(input logic sc_level);
        @(negedge clk);
        rstn = 1'b0;
        sample_clk = sc_level;
        hist.delete();
        exp_out = '0;
        repeat (2) @(negedge clk);
        check("reset_out", out, '0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        sample_clk = 1'b0;
        @(negedge clk);
        check("post_reset", out, '0);
    endtask

    initial begin
        // Basic delay
        do_reset(1'b0);
        for (int k = 0; k < 30; k++) do_tick("basic", (k < 5) ? W'(k + 1) : '0, 20, 1'b1);

        // Minimum delay; sample_clk high across reset release must not tick
        do_reset(1'b1);
        for (int k = 0; k < 10; k++) do_tick("min", W'(k), 0, 1'b1);

        // Maximum delay with wrap, then over-range clamp
        do_reset(1'b0);
        for (int k = 0; k < 70; k++) do_tick("max30", W'(k + 1), 30, 1'b1);
        do_reset(1'b0);
        for (int k = 0; k < 70; k++) do_tick("max40", W'(k + 1), 40, 1'b1);

        // Enable gating
        do_reset(1'b0);
        for (int k = 0; k < 6; k++) do_tick("en_pre", W'($urandom), 3, 1'b1);
        for (int k = 0; k < 5; k++) do_tick("en_off", W'($urandom), 3, 1'b0);
        for (int k = 0; k < 6; k++) do_tick("en_post", W'($urandom), 3, 1'b1);

        // Length change
        for (int k = 0; k < 15; k++) do_tick("len10", W'($urandom), 10, 1'b1);
        for (int k = 0; k < 4; k++) do_tick("len5", W'($urandom), 5, 1'b1);
        for (int k = 0; k < 4; k++) do_tick("len10b", W'($urandom), 10, 1'b1);

        // Asynchronous reset between clock edges
        @(posedge clk);
        #1 rstn = 1'b0;
        #0.5;
        check("async_rst", out, '0);
        hist.delete();
        exp_out = '0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 8; k++) do_tick("rst_len4", W'(k + 100), 4, 1'b1);

        // Randomized length and enable
        for (int k = 0; k < 150; k++)
            do_tick("random", W'($urandom), $urandom_range(0, 35), ($urandom_range(0, 3) != 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
